// File: rtl/fme_interp_scheduler.sv
// FME interpolation scheduler: runs the controller phases over every block of a CTU.
// Optional stall cycle counter is built when FME_SCHED_STALL_CNT_EN is defined.
module fme_interp_scheduler #(
  parameter int PH_CYCLES    = 16,
  parameter int PVPO_CYCLES  = 6,
  parameter int PVSO_CYCLES  = 26,
  parameter int NUM_BLOCKS   = 64,
  parameter int BLKS_PER_ROW = 8,
  parameter int BLK_IDX_W    = 6
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 stall,
  output logic                 interp_enable,
  output logic                 ph_finished,
  output logic                 pvpo_finished,
  output logic                 pvso_finished,
  output logic                 ctrl_clear,
  output logic [BLK_IDX_W-1:0] blk_idx,
  output logic [BLK_IDX_W-1:0] blk_x,
  output logic [BLK_IDX_W-1:0] blk_y,
  output logic                 blk_done,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          stall_count
);

  localparam int MAX_A = (PH_CYCLES > PVPO_CYCLES) ? PH_CYCLES : PVPO_CYCLES;
  localparam int MAX_C = (MAX_A > PVSO_CYCLES) ? MAX_A : PVSO_CYCLES;
  localparam int CW    = $clog2(MAX_C + 1);

  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [CW-1:0] PH_L   = CW'(PH_CYCLES - 1);
  localparam logic [CW-1:0] PVPO_L = CW'(PVPO_CYCLES - 1);
  localparam logic [CW-1:0] PVSO_L = CW'(PVSO_CYCLES - 1);

  localparam logic [BLK_IDX_W-1:0] B_ONE  = BLK_IDX_W'(1);
  localparam logic [BLK_IDX_W-1:0] B_LAST = BLK_IDX_W'(NUM_BLOCKS - 1);
  localparam logic [BLK_IDX_W-1:0] X_LAST = BLK_IDX_W'(BLKS_PER_ROW - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_BEGIN, S_PH, S_PVPO_SETUP, S_PVPO,
    S_PVSO_SETUP, S_PVSO, S_OVERLAP, S_LAST_OVERLAP, S_CLEAR
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CW-1:0]        r_cnt;
  logic [BLK_IDX_W-1:0] r_blk_idx;
  logic [BLK_IDX_W-1:0] r_blk_x;
  logic [BLK_IDX_W-1:0] r_blk_y;
  logic                 r_ie;
  logic                 r_clr;
  logic                 r_busy;
  logic                 w_ie_d;
  logic                 w_clr_d;
  logic                 w_busy_d;
  logic                 w_accept;
  logic                 w_in_phase;
  logic                 w_ph_fin;
  logic                 w_pvpo_fin;
  logic                 w_pvso_fin;
  logic                 w_fin;

  assign w_accept   = (r_state == S_IDLE) && start;
  assign w_in_phase = (r_state == S_PH) || (r_state == S_PVPO) ||
                      (r_state == S_PVSO);
  assign w_ph_fin   = (r_state == S_PH) && (r_cnt == PH_L) && !stall;
  assign w_pvpo_fin = (r_state == S_PVPO) && (r_cnt == PVPO_L) && !stall;
  assign w_pvso_fin = (r_state == S_PVSO) && (r_cnt == PVSO_L) && !stall;
  assign w_fin      = w_ph_fin || w_pvpo_fin || w_pvso_fin;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; stall only matters through the phase-finished terms
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:         if (start) w_next = S_START;
      S_START:        w_next = S_BEGIN;
      S_BEGIN:        w_next = S_PH;
      S_PH:           if (w_ph_fin) w_next = S_PVPO_SETUP;
      S_PVPO_SETUP:   w_next = S_PVPO;
      S_PVPO:         if (w_pvpo_fin) w_next = S_PVSO_SETUP;
      S_PVSO_SETUP:   w_next = S_PVSO;
      S_PVSO: begin
        if (w_pvso_fin) begin
          if (r_blk_idx < B_LAST) w_next = S_OVERLAP;
          else                    w_next = S_LAST_OVERLAP;
        end
      end
      S_OVERLAP:      w_next = S_PH;
      S_LAST_OVERLAP: w_next = S_CLEAR;
      S_CLEAR:        w_next = S_IDLE;
      default:        w_next = S_IDLE;
    endcase
  end

  // Output decode of the state being entered, so the registers track the state
  always_comb begin
    w_ie_d   = (w_next == S_START);
    w_clr_d  = (w_next == S_CLEAR);
    w_busy_d = (w_next != S_IDLE);
  end

  // Registered state-decoded outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ie   <= 1'b0;
      r_clr  <= 1'b0;
      r_busy <= 1'b0;
    end else begin
      r_ie   <= w_ie_d;
      r_clr  <= w_clr_d;
      r_busy <= w_busy_d;
    end
  end

  // Phase counter: advances on unstalled phase cycles, clears at phase end
  always_ff @(posedge clock or posedge reset) begin
    if (reset)                        r_cnt <= '0;
    else if (w_accept || w_fin)       r_cnt <= '0;
    else if (w_in_phase && !stall)    r_cnt <= r_cnt + C_ONE;
  end

  // Block index and raster position, stepped while the next block loads
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_blk_idx <= '0;
      r_blk_x   <= '0;
      r_blk_y   <= '0;
    end else if (w_accept) begin
      r_blk_idx <= '0;
      r_blk_x   <= '0;
      r_blk_y   <= '0;
    end else if (r_state == S_OVERLAP) begin
      r_blk_idx <= r_blk_idx + B_ONE;
      if (r_blk_x == X_LAST) begin
        r_blk_x <= '0;
        r_blk_y <= r_blk_y + B_ONE;
      end else begin
        r_blk_x <= r_blk_x + B_ONE;
      end
    end
  end

`ifdef FME_SCHED_STALL_CNT_EN
  logic [31:0] r_stall_count;

  // Saturating count of stalled phase cycles for the current CTU
  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_stall_count <= '0;
    else if (w_accept)
      r_stall_count <= '0;
    else if (w_in_phase && stall && (r_stall_count != 32'hFFFF_FFFF))
      r_stall_count <= r_stall_count + 32'd1;
  end

  assign stall_count = r_stall_count;
`else
  assign stall_count = 32'd0;
`endif

  assign interp_enable = r_ie;
  assign ph_finished   = w_ph_fin;
  assign pvpo_finished = w_pvpo_fin;
  assign pvso_finished = w_pvso_fin;
  assign blk_done      = w_pvso_fin;
  assign ctrl_clear    = r_clr;
  assign done          = r_clr;
  assign busy          = r_busy;
  assign blk_idx       = r_blk_idx;
  assign blk_x         = r_blk_x;
  assign blk_y         = r_blk_y;

endmodule
